// File: rtl/rfdp_fifo_ctrl.sv
// Valid/ready FIFO sequencer around an external rfdp dual-port macro.
// Reads are issued on credit into a small skid buffer that hides the macro read latency.
module rfdp_fifo_ctrl #(
  parameter  int DEPTH  = 512,
  parameter  int WIDTH  = 32,
  parameter  int RD_LAT = 2,
  localparam int AW     = $clog2(DEPTH),
  localparam int SKID   = RD_LAT + 1,
  localparam int LW     = $clog2(DEPTH + SKID + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [LW-1:0]    level,
  output logic [AW-1:0]    aa,
  output logic             cena,
  input  logic [WIDTH-1:0] qa,
  output logic [AW-1:0]    ab,
  output logic [WIDTH-1:0] db,
  output logic             cenb
);

  localparam int SPW = (SKID > 1) ? $clog2(SKID) : 1;
  localparam int SCW = $clog2(SKID + 1);

  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      ram_cnt;
  logic [RD_LAT-1:0] vld;
  logic [WIDTH-1:0] skid_mem [SKID];
  logic [SPW-1:0]   skid_hd, skid_tl;
  logic [SCW-1:0]   skid_cnt;
  logic [LW-1:0]    vld_cnt, credit;
  logic             push, pop, issue, cap;

  function automatic logic [SPW-1:0] skid_inc(input logic [SPW-1:0] p);
    return (p == SPW'(SKID - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    vld_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) vld_cnt = vld_cnt + LW'(vld[i]);
  end

  assign s_ready = !rst && (ram_cnt != (AW+1)'(DEPTH));
  assign m_valid = !rst && (skid_cnt != '0);
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  // Credit counts skid entries plus reads still travelling through the macro.
  assign credit  = LW'(skid_cnt) + vld_cnt - LW'(pop);
  assign issue   = !rst && (ram_cnt != '0) && (credit < LW'(SKID));
  assign cap     = vld[RD_LAT-1];

  // The macro output register is gated by cena, so it stays on outside reset.
  assign cena   = !rst;
  assign aa     = rst ? '0 : rptr;
  assign ab     = rst ? '0 : wptr;
  assign db     = s_data;
  assign cenb   = push;
  assign m_data = skid_mem[skid_hd];
  assign level  = rst ? '0 : LW'(ram_cnt) + vld_cnt + LW'(skid_cnt);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      vld      <= '0;
      skid_hd  <= '0;
      skid_tl  <= '0;
      skid_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (issue) rptr <= rptr + 1'b1;
      if (push && !issue) ram_cnt <= ram_cnt + 1'b1;
      else if (!push && issue) ram_cnt <= ram_cnt - 1'b1;
      vld <= (vld << 1) | RD_LAT'(issue);
      if (cap) skid_tl <= skid_inc(skid_tl);
      if (pop) skid_hd <= skid_inc(skid_hd);
      if (cap && !pop) skid_cnt <= skid_cnt + 1'b1;
      else if (!cap && pop) skid_cnt <= skid_cnt - 1'b1;
    end
  end

  // Skid storage needs no reset; occupancy is tracked by skid_cnt alone.
  always_ff @(posedge clk) begin
    if (!rst && !flush && cap) skid_mem[skid_tl] <= qa;
  end

endmodule

// File: tb/tb_rfdp_fifo_ctrl.sv
// Bench for rfdp_fifo_ctrl: vector table for cycle-exact behaviour, then
// scoreboarded streaming, full, random, flush and reset sequences.
module tb_rfdp_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, s_valid, s_ready, m_valid, m_ready, cena, cenb;
  logic [31:0] s_data, m_data, qa, db;
  logic [9:0]  level;
  logic [8:0]  aa, ab;

  always #5 clk = ~clk;

  rfdp_fifo_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level), .aa(aa), .cena(cena), .qa(qa),
    .ab(ab), .db(db), .cenb(cenb)
  );

  // Macro model: address registered on one edge, data registered on the next.
  logic [31:0] mem [512];
  logic [8:0]  aa_q;
  always @(posedge clk) begin
    if (cenb) mem[ab] <= db;
    if (cena) begin
      aa_q <= aa;
      qa   <= mem[aa_q];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, flush, sv;
    logic [31:0] sd;
    logic        mr;
    logic        er, ev;
    logic [31:0] ed;
    logic [9:0]  el;
    logic        ec;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic sv, input logic [31:0] sd,
                              input logic mr, input logic er, input logic ev,
                              input logic [31:0] ed, input logic [9:0] el, input logic ec);
    vec_t v;
    v.rst = r; v.flush = 1'b0; v.sv = sv; v.sd = sd; v.mr = mr;
    v.er = er; v.ev = ev; v.ed = ed; v.el = el; v.ec = ec;
    return v;
  endfunction

  logic [31:0] sb [$];
  logic        stall_q;
  logic [31:0] stall_d;

  // Called at the sample point of each cycle.
  task automatic obs(input string nm);
    logic [31:0] e;
    if (stall_q) begin
      chk({nm, " hold valid"}, {31'b0, m_valid}, 32'd1);
      chk({nm, " hold data"}, m_data, stall_d);
    end
    if (s_valid && s_ready) sb.push_back(s_data);
    if (m_valid && m_ready) begin
      if (sb.size() == 0) chk({nm, " unexpected word"}, m_data, 32'hxxxx_xxxx);
      else begin
        e = sb.pop_front();
        chk({nm, " data"}, m_data, e);
      end
    end
    stall_q = m_valid && !m_ready;
    stall_d = m_data;
  endtask

  task automatic drain(input string nm);
    int c;
    c = 0;
    while ((sb.size() != 0 || m_valid) && c < 2000) begin
      @(negedge clk);
      s_valid = 1'b0; m_ready = 1'b1;
      #1 obs(nm);
      c++;
    end
    chk({nm, " drain done"}, {31'b0, c < 2000}, 32'd1);
    @(negedge clk); #1;
    chk({nm, " level empty"}, {22'b0, level}, 32'd0);
  endtask

  vec_t tv [15];

  initial begin
    int sent, recv, gaps, acc, cyc;
    logic seen;

    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    stall_q = 1'b0; stall_d = '0;
    repeat (3) @(negedge clk);

    // Single word latency and two back-to-back words.
    tv[0]  = mk(1, 1, 32'hDEAD_0000, 1, 0, 0, 32'h0,          0, 0);
    tv[1]  = mk(0, 1, 32'hA5A5_0001, 0, 1, 0, 32'h0,          0, 1);
    tv[2]  = mk(0, 0, 32'h0,         0, 1, 0, 32'h0,          1, 0);
    tv[3]  = mk(0, 0, 32'h0,         0, 1, 0, 32'h0,          1, 0);
    tv[4]  = mk(0, 0, 32'h0,         0, 1, 0, 32'h0,          1, 0);
    tv[5]  = mk(0, 0, 32'h0,         0, 1, 1, 32'hA5A5_0001, 1, 0);
    tv[6]  = mk(0, 0, 32'h0,         0, 1, 1, 32'hA5A5_0001, 1, 0);
    tv[7]  = mk(0, 0, 32'h0,         1, 1, 1, 32'hA5A5_0001, 1, 0);
    tv[8]  = mk(0, 1, 32'h1111_1111, 1, 1, 0, 32'h0,          0, 1);
    tv[9]  = mk(0, 1, 32'h2222_2222, 1, 1, 0, 32'h0,          1, 1);
    tv[10] = mk(0, 0, 32'h0,         1, 1, 0, 32'h0,          2, 0);
    tv[11] = mk(0, 0, 32'h0,         1, 1, 0, 32'h0,          2, 0);
    tv[12] = mk(0, 0, 32'h0,         1, 1, 1, 32'h1111_1111, 2, 0);
    tv[13] = mk(0, 0, 32'h0,         1, 1, 1, 32'h2222_2222, 1, 0);
    tv[14] = mk(0, 0, 32'h0,         1, 1, 0, 32'h0,          0, 0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rst = tv[i].rst; flush = tv[i].flush; s_valid = tv[i].sv;
      s_data = tv[i].sd; m_ready = tv[i].mr;
      #1;
      chk($sformatf("vec%0d s_ready", i), {31'b0, s_ready}, {31'b0, tv[i].er});
      chk($sformatf("vec%0d m_valid", i), {31'b0, m_valid}, {31'b0, tv[i].ev});
      chk($sformatf("vec%0d level", i), {22'b0, level}, {22'b0, tv[i].el});
      chk($sformatf("vec%0d cenb", i), {31'b0, cenb}, {31'b0, tv[i].ec});
      if (tv[i].ev) chk($sformatf("vec%0d m_data", i), m_data, tv[i].ed);
    end

    // Streaming: 2000 words, one per cycle with no output gaps.
    sent = 0; recv = 0; gaps = 0; seen = 1'b0; cyc = 0;
    while (recv < 2000 && cyc < 2100) begin
      @(negedge clk);
      s_valid = (sent < 2000); s_data = 32'h1000_0000 + sent; m_ready = 1'b1;
      #1;
      if (m_valid) seen = 1'b1;
      else if (seen) gaps++;
      if (m_valid && m_ready) recv++;
      if (s_valid && s_ready) sent++;
      obs("stream");
      cyc++;
    end
    chk("stream count", recv, 32'd2000);
    chk("stream gaps", gaps, 32'd0);

    // Fill until full with the consumer stalled.
    acc = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 32'h2000_0000 + acc; m_ready = 1'b0;
      #1;
      if (s_valid && s_ready) acc++;
      obs("full");
    end
    chk("full accepted", acc, 32'd515);
    chk("full level", {22'b0, level}, 32'd515);
    chk("full s_ready", {31'b0, s_ready}, 32'd0);
    drain("full");

    // Random handshakes across pointer wrap.
    sent = 0; cyc = 0;
    while (sent < 4000 && cyc < 40000) begin
      @(negedge clk);
      s_valid = 1'($urandom_range(0, 1)); s_data = 32'h3000_0000 + sent;
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (s_valid && s_ready) sent++;
      obs("rand");
      cyc++;
    end
    chk("rand pushed", sent, 32'd4000);
    drain("rand");

    // Flush with words in RAM, in flight and in the skid buffer.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 32'h4000_0000 + i; m_ready = 1'b0;
      #1 obs("preflush");
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_valid = 1'b0; m_ready = 1'b1;
      #1 obs("preflush");
    end
    @(negedge clk);
    flush = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD_F1F1; m_ready = 1'b0;
    @(negedge clk);
    flush = 1'b0; s_valid = 1'b0;
    sb.delete(); stall_q = 1'b0;
    #1;
    chk("flush m_valid", {31'b0, m_valid}, 32'd0);
    chk("flush level", {22'b0, level}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); m_ready = 1'b1;
      #1 chk("flush idle m_valid", {31'b0, m_valid}, 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 32'hF00D_0001 + i; m_ready = 1'b1;
      #1 obs("postflush");
    end
    drain("postflush");

    // One-cycle reset in the middle of a stream.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 32'h5000_0000 + i; m_ready = 1'b1;
      #1 obs("prerst");
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst s_ready", {31'b0, s_ready}, 32'd0);
    chk("rst m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst cena", {31'b0, cena}, 32'd0);
    chk("rst cenb", {31'b0, cenb}, 32'd0);
    chk("rst aa", {23'b0, aa}, 32'd0);
    chk("rst ab", {23'b0, ab}, 32'd0);
    chk("rst level", {22'b0, level}, 32'd0);
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0;
    sb.delete(); stall_q = 1'b0;
    #1 chk("postrst level", {22'b0, level}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 chk("postrst idle m_valid", {31'b0, m_valid}, 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 32'hC0DE_0001 + i; m_ready = 1'b1;
      #1 obs("postrst");
    end
    drain("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
